// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and address helpers for the slave register file.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  function automatic int unsigned addr_lsb_of(input int unsigned data_bits);
    return (data_bits == 64) ? 3 : 2;
  endfunction

  // Word index of a byte address; byte-offset bits are discarded.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                               input int unsigned addr_lsb);
    return addr >> addr_lsb;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) (
  input logic i_clk
);

  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slv_port (
    input  i_clk,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    input  i_clk,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_slv_wr_ctrl.sv
// Write-side control: independent AW/W capture, commit sequencing and B response.
module axi4_lite_slv_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_BIT_WIDTH = 32,
  parameter int                    DATA_BIT_WIDTH = 32,
  parameter int                    NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK        = '0,
  parameter int                    IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_sync_rst,
  input  logic [ADDR_BIT_WIDTH-1:0]   awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_BIT_WIDTH-1:0]   wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  output logic                        wr_en,
  output logic [IDX_W-1:0]            wr_idx,
  output logic [DATA_BIT_WIDTH-1:0]   wr_data,
  output logic [DATA_BIT_WIDTH/8-1:0] wr_strb
);

  localparam int unsigned ADDR_LSB = addr_lsb_of(DATA_BIT_WIDTH);
  localparam int          RO_W     = 2 ** IDX_W;

  wr_state_t                   state_reg, state_next;
  logic [ADDR_BIT_WIDTH-1:0]   addr_reg;
  logic [DATA_BIT_WIDTH-1:0]   data_reg;
  logic [DATA_BIT_WIDTH/8-1:0] strb_reg;
  resp_t                       bresp_reg;

  logic              aw_hs, w_hs;
  logic [63:0]       idx_full;
  logic [IDX_W-1:0]  idx;
  logic [RO_W-1:0]   ro_ext;
  logic              in_range, writable;

  assign awready = !i_sync_rst && (state_reg == WR_IDLE || state_reg == WR_HAVE_DATA);
  assign wready  = !i_sync_rst && (state_reg == WR_IDLE || state_reg == WR_HAVE_ADDR);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign idx_full = addr_to_idx(64'(addr_reg), ADDR_LSB);
  assign idx      = idx_full[IDX_W-1:0];
  assign in_range = idx_full < 64'(NUM_REGS);
  assign ro_ext   = RO_W'(RO_MASK);
  assign writable = in_range && !ro_ext[idx];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) state_next = WR_COMMIT;
        else if (aw_hs)    state_next = WR_HAVE_ADDR;
        else if (w_hs)     state_next = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)  state_next = WR_COMMIT;
      WR_HAVE_DATA: if (aw_hs) state_next = WR_COMMIT;
      WR_COMMIT:               state_next = WR_RESP;
      WR_RESP:      if (bready) state_next = WR_IDLE;
      default:                 state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_reg <= WR_IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      strb_reg  <= '0;
      bresp_reg <= OKAY;
    end else begin
      state_reg <= state_next;
      if (aw_hs) addr_reg <= awaddr;
      if (w_hs) begin
        data_reg <= wdata;
        strb_reg <= wstrb;
      end
      if (state_reg == WR_COMMIT) bresp_reg <= writable ? OKAY : SLVERR;
    end
  end

  assign bvalid  = (state_reg == WR_RESP);
  assign bresp   = bresp_reg;
  assign wr_en   = (state_reg == WR_COMMIT) && writable;
  assign wr_idx  = idx;
  assign wr_data = data_reg;
  assign wr_strb = strb_reg;

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave exposing NUM_REGS registers with read-only masking and write strobes.
module axi4_lite_slv_reg_file
  import axi4_lite_pkg::*;
#(
  parameter int                          ADDR_BIT_WIDTH = 32,
  parameter int                          DATA_BIT_WIDTH = 32,
  parameter int                          NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0]         RO_MASK        = '0,
  parameter logic [DATA_BIT_WIDTH-1:0]   RESET_VAL      = '0
) (
  input  logic                                i_clk,
  input  logic                                i_sync_rst,
  axi4_lite_if.slv_port                       axi_if,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  i_ro_vals,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  o_regs,
  output logic [NUM_REGS-1:0]                 o_wr_pulse
);

  localparam int          DW       = DATA_BIT_WIDTH;
  localparam int          SW       = DATA_BIT_WIDTH / 8;
  localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned ADDR_LSB = addr_lsb_of(DATA_BIT_WIDTH);

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [DW-1:0]    rd_val [NUM_REGS];

  axi4_lite_slv_wr_ctrl #(
    .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
    .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .RO_MASK        (RO_MASK),
    .IDX_W          (IDX_W)
  ) u_wr_ctrl (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .awaddr     (axi_if.awaddr),
    .awvalid    (axi_if.awvalid),
    .awready    (axi_if.awready),
    .wdata      (axi_if.wdata),
    .wstrb      (axi_if.wstrb),
    .wvalid     (axi_if.wvalid),
    .wready     (axi_if.wready),
    .bresp      (axi_if.bresp),
    .bvalid     (axi_if.bvalid),
    .bready     (axi_if.bready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
        assign rd_val[gi]               = i_ro_vals[gi*DW +: DW];
        assign o_regs[gi*DW +: DW]      = '0;
        assign o_wr_pulse[gi]           = 1'b0;
      end else begin : g_rw
        logic [DW-1:0] val_reg;
        logic          pulse_reg;
        logic          sel;
        logic          unused_ro;

        assign sel       = wr_en && (wr_idx == IDX_W'(gi));
        assign unused_ro = ^i_ro_vals[gi*DW +: DW];

        always_ff @(posedge i_clk) begin
          if (i_sync_rst) begin
            val_reg   <= RESET_VAL;
            pulse_reg <= 1'b0;
          end else begin
            pulse_reg <= sel;
            if (sel) begin
              for (int b = 0; b < SW; b++) begin
                if (wr_strb[b]) val_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
              end
            end
          end
        end

        assign rd_val[gi]          = val_reg;
        assign o_regs[gi*DW +: DW] = val_reg;
        assign o_wr_pulse[gi]      = pulse_reg;
      end
    end
  endgenerate

  // Read path: single-entry response buffer, one-cycle latency after AR.
  logic             rvalid_reg;
  logic [DW-1:0]    rdata_reg;
  resp_t            rresp_reg;
  logic             ar_hs;
  logic [63:0]      rd_idx_full;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic             unused_prot;

  assign axi_if.arready = !i_sync_rst && !rvalid_reg;
  assign ar_hs          = axi_if.arvalid && axi_if.arready;
  assign rd_idx_full    = addr_to_idx(64'(axi_if.araddr), ADDR_LSB);
  assign rd_idx         = rd_idx_full[IDX_W-1:0];
  assign rd_in_range    = rd_idx_full < 64'(NUM_REGS);
  assign unused_prot    = ^{axi_if.awprot, axi_if.arprot};

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_in_range ? rd_val[rd_idx] : '0;
      rresp_reg  <= rd_in_range ? OKAY : SLVERR;
    end else if (rvalid_reg && axi_if.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign axi_if.rvalid = rvalid_reg;
  assign axi_if.rdata  = rdata_reg;
  assign axi_if.rresp  = rresp_reg;

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Scoreboard bench: stimulus queues expected B/R responses, a negedge monitor checks them.
module tb_axi4_lite_slv_reg_file;

  localparam logic [7:0]  RO_MASK   = 8'h60;
  localparam logic [31:0] RESET_VAL = 32'hCAFE_BABE;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic         clk = 1'b0;
  logic         srst;
  logic [255:0] ro_vals;
  logic [255:0] regs;
  logic [7:0]   pulse;
  logic [7:0]   pulse_acc = '0;

  logic [1:0]   exp_b [$];
  r_exp_t       exp_r [$];
  logic [1:0]   mon_b;
  r_exp_t       mon_r;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus (.i_clk(clk));

  axi4_lite_slv_reg_file #(
    .ADDR_BIT_WIDTH (32),
    .DATA_BIT_WIDTH (32),
    .NUM_REGS       (8),
    .RO_MASK        (RO_MASK),
    .RESET_VAL      (RESET_VAL)
  ) dut (
    .i_clk      (clk),
    .i_sync_rst (srst),
    .axi_if     (bus),
    .i_ro_vals  (ro_vals),
    .o_regs     (regs),
    .o_wr_pulse (pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return regs[k*32 +: 32];
  endfunction

  // Monitor: compare every B and R handshake against the head of its queue.
  always @(negedge clk) begin
    pulse_acc = pulse_acc | pulse;
    if (bus.bvalid && bus.bready) begin
      if (exp_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_b: got bresp %0d, expected no response", bus.bresp);
      end else begin
        mon_b = exp_b.pop_front();
        chk("bresp", 64'(bus.bresp), 64'(mon_b));
        $display("B  bresp=%0d", bus.bresp);
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (exp_r.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_r: got rdata 0x%0h, expected no response", bus.rdata);
      end else begin
        mon_r = exp_r.pop_front();
        chk("rdata", 64'(bus.rdata), 64'(mon_r.data));
        chk("rresp", 64'(bus.rresp), 64'(mon_r.resp));
        $display("R  rdata=0x%08h rresp=%0d", bus.rdata, bus.rresp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr);
    bit done = 1'b0;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = bus.awready;
      tick();
    end
    bus.awvalid = 1'b0;
    if (!done) timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit done = 1'b0;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = bus.wready;
      tick();
    end
    bus.wvalid = 1'b0;
    if (!done) timeout("w_handshake");
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    bit done = 1'b0;
    exp_r.push_back('{data, resp});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = bus.arready;
      tick();
    end
    bus.arvalid = 1'b0;
    if (!done) timeout("ar_handshake");
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (exp_b.size() != 0 || exp_r.size() != 0); i++) tick();
    chk("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
  endtask

  task automatic wait_bvalid();
    for (int i = 0; i < 40 && !bus.bvalid; i++) tick();
    if (!bus.bvalid) timeout("bvalid_wait");
  endtask

  initial begin
    srst        = 1'b1;
    ro_vals     = {8{32'hFFFF_FFFF}};
    ro_vals[5*32 +: 32] = 32'h5555_0005;
    ro_vals[6*32 +: 32] = 32'h6666_0006;
    bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_pulse",   64'(pulse),       64'd0);
    chk("rst_reg0",    64'(reg_of(0)),   64'(RESET_VAL));
    chk("rst_reg5_ro", 64'(reg_of(5)),   64'd0);
    srst = 1'b0;
    tick();

    // Same-cycle AW+W; B arrives two cycles after the handshake cycle
    write(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00);
    chk("b_early",   64'(bus.bvalid), 64'd0);
    tick();
    chk("b_latency", 64'(bus.bvalid), 64'd1);
    chk("pulse1_on", 64'(pulse),      64'h02);
    chk("reg1",      64'(reg_of(1)),  64'hDEAD_BEEF);
    tick();
    chk("pulse1_off", 64'(pulse),     64'd0);
    wait_idle();
    send_ar(32'h04, 32'hDEAD_BEEF, 2'b00);
    chk("r_latency", 64'(bus.rvalid), 64'd1);
    wait_idle();

    // W five cycles ahead of AW, sparse strobes
    write(32'h08, 32'hAABB_CCDD, 4'hF, 2'b00);
    wait_idle();
    chk("reg2_init", 64'(reg_of(2)), 64'hAABB_CCDD);
    exp_b.push_back(2'b00);
    send_w(32'h1122_3344, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      chk("w_first_wready",  64'(bus.wready),  64'd0);
      chk("w_first_awready", 64'(bus.awready), 64'd1);
      tick();
    end
    send_aw(32'h08);
    wait_idle();
    chk("reg2_strb", 64'(reg_of(2)), 64'hAA22_CC44);

    // Out-of-range and read-only writes, then reads
    pulse_acc = '0;
    write(32'h40, 32'h1234_5678, 4'hF, 2'b10);
    wait_idle();
    write(32'h14, 32'h0000_0000, 4'hF, 2'b10);
    wait_idle();
    chk("err_no_pulse", 64'(pulse_acc),  64'd0);
    chk("err_reg0",     64'(reg_of(0)),  64'(RESET_VAL));
    chk("err_reg5",     64'(reg_of(5)),  64'd0);
    chk("err_reg1",     64'(reg_of(1)),  64'hDEAD_BEEF);
    send_ar(32'h40, 32'h0, 2'b10);
    send_ar(32'h14, 32'h5555_0005, 2'b00);
    send_ar(32'h18, 32'h6666_0006, 2'b00);
    send_ar(32'h06, 32'hDEAD_BEEF, 2'b00);
    send_ar(32'h00, RESET_VAL, 2'b00);
    wait_idle();

    // Back-pressure on B and R
    bus.bready = 1'b0;
    write(32'h40, 32'h0, 4'hF, 2'b10);
    wait_bvalid();
    for (int i = 0; i < 10; i++) begin
      chk("bhold_bvalid",  64'(bus.bvalid),  64'd1);
      chk("bhold_bresp",   64'(bus.bresp),   64'd2);
      chk("bhold_awready", 64'(bus.awready), 64'd0);
      chk("bhold_wready",  64'(bus.wready),  64'd0);
      tick();
    end
    bus.bready = 1'b1;
    wait_idle();
    bus.rready = 1'b0;
    send_ar(32'h04, 32'hDEAD_BEEF, 2'b00);
    for (int i = 0; i < 10; i++) begin
      chk("rhold_rvalid",  64'(bus.rvalid),  64'd1);
      chk("rhold_rdata",   64'(bus.rdata),   64'hDEAD_BEEF);
      chk("rhold_arready", 64'(bus.arready), 64'd0);
      tick();
    end
    bus.rready = 1'b1;
    wait_idle();

    // Read sampled at the commit edge returns the old value
    write(32'h0C, 32'h0, 4'hF, 2'b00);
    wait_idle();
    chk("reg3_zero", 64'(reg_of(3)), 64'd0);
    write(32'h0C, 32'h5, 4'hF, 2'b00);
    send_ar(32'h0C, 32'h0, 2'b00);
    wait_idle();
    send_ar(32'h0C, 32'h5, 2'b00);
    wait_idle();

    // Reset while B is pending and a new AW is waiting
    bus.bready = 1'b0;
    write(32'h1C, 32'h7777_7777, 4'hF, 2'b00);
    wait_bvalid();
    chk("reg7_pre", 64'(reg_of(7)), 64'h7777_7777);
    bus.awaddr  = 32'h04;
    bus.awvalid = 1'b1;
    tick();
    chk("aw_blocked", 64'(bus.awready), 64'd0);
    srst = 1'b1;
    exp_b.delete();
    tick();
    bus.awvalid = 1'b0;
    srst = 1'b0;
    chk("rst_mid_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_mid_reg7",   64'(reg_of(7)),  64'(RESET_VAL));
    chk("rst_mid_reg1",   64'(reg_of(1)),  64'(RESET_VAL));
    chk("rst_mid_reg2",   64'(reg_of(2)),  64'(RESET_VAL));
    bus.bready = 1'b1;
    repeat (5) tick();
    chk("post_rst_awready", 64'(bus.awready), 64'd1);
    write(32'h1C, 32'h1234_0000, 4'b1100, 2'b00);
    wait_idle();
    chk("reg7_post", 64'(reg_of(7)), 64'h1234_BABE);
    send_ar(32'h1C, 32'h1234_BABE, 2'b00);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
